// File: rtl/cpu_debug_jtag_initiator_if.sv
// Command/response handshake and virtual-JTAG pin bundle for the debug initiator.
// The master modport is the initiator side; slave is the host/debug-slave side.
interface cpu_debug_jtag_initiator_if #(
  parameter int DATA_W = 38,
  parameter int IR_W   = 2
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [IR_W-1:0]   cmd_ir;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              tck;
  logic              tdi;
  logic              tdo;
  logic [IR_W-1:0]   ir_in;
  logic              vs_uir;
  logic              vs_cdr;
  logic              vs_sdr;
  logic              vs_udr;
  logic              jtag_state_rti;

  modport master (
    input  cmd_valid, cmd_ir, cmd_data, tdo,
    output cmd_ready, rsp_valid, rsp_data, tck, tdi, ir_in,
           vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti
  );

  modport slave (
    output cmd_valid, cmd_ir, cmd_data, tdo,
    input  cmd_ready, rsp_valid, rsp_data, tck, tdi, ir_in,
           vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti
  );
endinterface

// File: rtl/cpu_debug_jtag_initiator.sv
// Virtual-JTAG initiator: runs one UIR -> CDR -> SDR x DATA_W -> UDR -> RTI sequence
// per accepted command, shifting cmd_data out on tdi and returning the captured tdo bits.
module cpu_debug_jtag_initiator #(
  parameter int DATA_W     = 38,
  parameter int IR_W       = 2,
  parameter int TCK_DIV    = 2,
  parameter int RTI_CYCLES = 2
) (
  input logic                        clk,
  input logic                        reset_n,
  cpu_debug_jtag_initiator_if.master io_bus
);

  localparam int CNT_MAX = (DATA_W > RTI_CYCLES) ? DATA_W : RTI_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DIV_W   = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
  localparam logic [CNT_W-1:0] SDR_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] RTI_LAST = CNT_W'(RTI_CYCLES - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_UIR  = 3'd1;
  localparam logic [2:0] ST_CDR  = 3'd2;
  localparam logic [2:0] ST_SDR  = 3'd3;
  localparam logic [2:0] ST_UDR  = 3'd4;
  localparam logic [2:0] ST_RTI  = 3'd5;

  logic [2:0]        r_state;
  logic [DIV_W-1:0]  r_div;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_tck;
  logic              r_tdi;
  logic [IR_W-1:0]   r_ir;
  logic [DATA_W-1:0] r_sh;
  logic [DATA_W-1:0] r_cap;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_uir;
  logic              r_cdr;
  logic              r_sdr;
  logic              r_udr;
  logic              r_rti;

  logic w_idle;
  logic w_half_end;
  logic w_period_end;
  logic w_capture;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_half_end   = (r_div == DIV_LAST);
  // A period ends on the last high cycle; the next edge drops tck and moves the FSM together.
  assign w_period_end = !w_idle && r_tck && w_half_end;
  assign w_capture    = (r_state == ST_SDR) && r_tck && (r_div == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tck <= 1'b0;
      r_div <= '0;
    end else if (w_idle) begin
      r_tck <= 1'b0;
      r_div <= '0;
    end else if (w_half_end) begin
      r_tck <= ~r_tck;
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Capture arrives from the top so that after DATA_W shifts the first bit sits at bit 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cap <= '0;
    end else if (w_capture) begin
      r_cap <= (r_cap >> 1) | (DATA_W'(io_bus.tdo) << (DATA_W - 1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ir        <= '0;
      r_sh        <= '0;
      r_tdi       <= 1'b0;
      r_uir       <= 1'b0;
      r_cdr       <= 1'b0;
      r_sdr       <= 1'b0;
      r_udr       <= 1'b0;
      r_rti       <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_idle) begin
        if (io_bus.cmd_valid) begin
          r_state <= ST_UIR;
          r_ir    <= io_bus.cmd_ir;
          r_sh    <= io_bus.cmd_data;
          r_rti   <= 1'b0;
          r_uir   <= 1'b1;
        end
      end else if (w_period_end) begin
        case (r_state)
          ST_UIR: begin
            r_state <= ST_CDR;
            r_uir   <= 1'b0;
            r_cdr   <= 1'b1;
          end
          ST_CDR: begin
            r_state <= ST_SDR;
            r_cdr   <= 1'b0;
            r_sdr   <= 1'b1;
            r_cnt   <= '0;
            r_tdi   <= r_sh[0];
            r_sh    <= r_sh >> 1;
          end
          ST_SDR: begin
            if (r_cnt == SDR_LAST) begin
              r_state <= ST_UDR;
              r_sdr   <= 1'b0;
              r_udr   <= 1'b1;
              r_tdi   <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
              r_tdi <= r_sh[0];
              r_sh  <= r_sh >> 1;
            end
          end
          ST_UDR: begin
            r_state <= ST_RTI;
            r_udr   <= 1'b0;
            r_rti   <= 1'b1;
            r_cnt   <= '0;
          end
          ST_RTI: begin
            if (r_cnt == RTI_LAST) begin
              r_state     <= ST_IDLE;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= r_cap;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_uir   <= 1'b0;
            r_cdr   <= 1'b0;
            r_sdr   <= 1'b0;
            r_udr   <= 1'b0;
            r_rti   <= 1'b1;
            r_tdi   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign io_bus.cmd_ready      = w_idle;
  assign io_bus.rsp_valid      = r_rsp_valid;
  assign io_bus.rsp_data       = r_rsp_data;
  assign io_bus.tck            = r_tck;
  assign io_bus.tdi            = r_tdi;
  assign io_bus.ir_in          = r_ir;
  assign io_bus.vs_uir         = r_uir;
  assign io_bus.vs_cdr         = r_cdr;
  assign io_bus.vs_sdr         = r_sdr;
  assign io_bus.vs_udr         = r_udr;
  assign io_bus.jtag_state_rti = r_rti;

endmodule
